// File: rtl/cam_downsampler.sv
// cam_downsampler: OV7670 RGB565 capture packed to RGB332 frame buffer writes; define TEST_PATTERN_EN for colour bars
module cam_downsampler #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_W        = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        CAM_DATA,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  output logic [7:0]        PIXEL_OUT,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic              W_EN,
  output logic [9:0]        X_ADDR,
  output logic [9:0]        Y_ADDR,
  output logic              FRAME_DONE
);
  localparam logic [1:0] SYNC = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] LINE = 2'd2;
  localparam logic [9:0] W10 = 10'(SCREEN_WIDTH);
  localparam logic [9:0] H10 = 10'(SCREEN_HEIGHT);
  localparam logic [9:0] SAT = 10'd1023;
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_WIDTH);
  logic [1:0] state;
  logic href_q, vsync_q, phase, wrote;
  logic [9:0] x, y;
  logic [ADDR_W-1:0] row_base;
  logic vsync_rise, vsync_fall, href_fall, capture, in_bounds;
  logic [7:0] pixel;
  assign vsync_rise = CAM_VSYNC & ~vsync_q;
  assign vsync_fall = ~CAM_VSYNC & vsync_q;
  assign href_fall  = ~CAM_HREF & href_q;
  assign capture    = state != SYNC && CAM_HREF && !vsync_rise;
  assign in_bounds  = x < W10 && y < H10;
`ifdef TEST_PATTERN_EN
  assign pixel = y < 10'd48 ? 8'hE0 : y < 10'd96 ? 8'h1C : 8'h03;
`else
  logic [5:0] hi;
  assign pixel = {hi, CAM_DATA[4:3]};
  // first byte of a pixel keeps only the bits that survive RGB332 packing
  always_ff @(posedge CLK) begin
    if (RESET) hi <= '0;
    else if (capture && !phase) hi <= {CAM_DATA[7:5], CAM_DATA[2:0]};
  end
`endif
  // frame/line sequencing, pixel counting and the registered write port
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= SYNC;
      href_q <= 1'b0;
      vsync_q <= 1'b0;
      phase <= 1'b0;
      wrote <= 1'b0;
      x <= '0;
      y <= '0;
      row_base <= '0;
      PIXEL_OUT <= '0;
      W_ADDR <= '0;
      W_EN <= 1'b0;
      X_ADDR <= '0;
      Y_ADDR <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      href_q <= CAM_HREF;
      vsync_q <= CAM_VSYNC;
      W_EN <= 1'b0;
      FRAME_DONE <= 1'b0;
      if (state == SYNC) begin
        if (vsync_fall) state <= IDLE;
      end else if (vsync_rise) begin
        FRAME_DONE <= wrote;
        wrote <= 1'b0;
        x <= '0;
        y <= '0;
        row_base <= '0;
        phase <= 1'b0;
        state <= IDLE;
      end else if (state == LINE && href_fall) begin
        x <= '0;
        phase <= 1'b0;
        state <= IDLE;
        if (y != SAT) y <= y + 10'd1;
        if (y < H10) row_base <= row_base + ROW_STEP;
      end else if (capture) begin
        state <= LINE;
        phase <= ~phase;
        if (phase) begin
          if (x != SAT) x <= x + 10'd1;
          if (in_bounds) begin
            W_EN <= 1'b1;
            PIXEL_OUT <= pixel;
            W_ADDR <= row_base + ADDR_W'(x);
            X_ADDR <= x;
            Y_ADDR <= y;
            wrote <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_cam_downsampler.sv
// tb_cam_downsampler: scoreboard bench for the camera capture front end
module tb_cam_downsampler;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [7:0] CAM_DATA = '0;
  logic CAM_HREF = 1'b0;
  logic CAM_VSYNC = 1'b0;
  logic [7:0] PIXEL_OUT;
  logic [14:0] W_ADDR;
  logic W_EN;
  logic [9:0] X_ADDR, Y_ADDR;
  logic FRAME_DONE;
  int checks = 0;
  int failures = 0;
  int fd_count = 0;
  int wr_count = 0;
  logic [14:0] last_addr = '0;
  logic [42:0] sb[$];
  logic [42:0] exp_w;
  int base_wr, base_fd;

  cam_downsampler dut (
    .CLK(CLK), .RESET(RESET), .CAM_DATA(CAM_DATA), .CAM_HREF(CAM_HREF), .CAM_VSYNC(CAM_VSYNC),
    .PIXEL_OUT(PIXEL_OUT), .W_ADDR(W_ADDR), .W_EN(W_EN), .X_ADDR(X_ADDR), .Y_ADDR(Y_ADDR),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1500000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // every write strobe must match the oldest expected write
  always @(negedge CLK) begin
    if (FRAME_DONE) fd_count++;
    if (W_EN) begin
      wr_count++;
      last_addr = W_ADDR;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write got addr=%0d pix=%h exp none", W_ADDR, PIXEL_OUT);
      end
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        assert ({W_ADDR, PIXEL_OUT, X_ADDR, Y_ADDR} === exp_w) else begin
          failures++;
          $error("FAIL write got addr=%0d pix=%h x=%0d y=%0d exp addr=%0d pix=%h x=%0d y=%0d",
                 W_ADDR, PIXEL_OUT, X_ADDR, Y_ADDR, exp_w[42:28], exp_w[27:20], exp_w[19:10], exp_w[9:0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic h, input logic v);
    @(negedge CLK);
    CAM_DATA = d;
    CAM_HREF = h;
    CAM_VSYNC = v;
  endtask

  task automatic pix(input int x, input int y, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] p, input bit en);
    drive(b0, 1'b1, 1'b0);
    drive(b1, 1'b1, 1'b0);
    if (en && x < 176 && y < 144) sb.push_back({15'(y * 176 + x), p, 10'(x), 10'(y)});
  endtask

  task automatic line(input int y, input int n, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] p, input bit en, input bit odd);
    for (int x = 0; x < n; x++) pix(x, y, b0, b1, p, en);
    if (odd) drive(b0, 1'b1, 1'b0);
    repeat (2) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic vs_rise();
    repeat (3) drive(8'h00, 1'b0, 1'b1);
  endtask

  task automatic vs_fall();
    repeat (3) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix"}, 32'(PIXEL_OUT), 0);
    chk({tag, "_addr"}, 32'(W_ADDR), 0);
    chk({tag, "_wen"}, 32'(W_EN), 0);
    chk({tag, "_x"}, 32'(X_ADDR), 0);
    chk({tag, "_y"}, 32'(Y_ADDR), 0);
    chk({tag, "_fd"}, 32'(FRAME_DONE), 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RESET = 1'b0;
    for (int l = 0; l < 4; l++) line(l, 20, 8'hF8, 8'h00, 8'hE0, 1'b0, 1'b0);
    vs_rise();
    chk("sync_writes", wr_count, 0);
    chk("sync_fd", fd_count, 0);
    vs_fall();
    line(0, 176, 8'hF8, 8'h00, 8'hE0, 1'b1, 1'b0);
    line(1, 176, 8'h00, 8'h1F, 8'h03, 1'b1, 1'b0);
    line(2, 176, 8'h07, 8'hE0, 8'h1C, 1'b1, 1'b0);
    line(3, 5, 8'h00, 8'h1F, 8'h03, 1'b1, 1'b1);
    line(4, 3, 8'h07, 8'hE0, 8'h1C, 1'b1, 1'b0);
    vs_rise();
    chk("a_writes", wr_count, 536);
    chk("a_fd", fd_count, 1);
    chk("a_sb_empty", sb.size(), 0);
    vs_fall();
    base_wr = wr_count;
    for (int l = 0; l < 145; l++) line(l, 200, 8'hF8, 8'h00, 8'hE0, 1'b1, 1'b0);
    vs_rise();
    chk("b_writes", wr_count - base_wr, 25344);
    chk("b_last_addr", 32'(last_addr), 25343);
    chk("b_fd", fd_count, 2);
    chk("b_sb_empty", sb.size(), 0);
    vs_fall();
    line(0, 0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    for (int x = 0; x < 4; x++) pix(x, 0, 8'hF8, 8'h00, 8'hE0, 1'b1);
    drive(8'hF8, 1'b1, 1'b0);
    drive(8'h00, 1'b1, 1'b1);
    vs_rise();
    chk("c_vs_mid_line_fd", fd_count, 3);
    vs_fall();
    for (int x = 0; x < 2; x++) pix(x, 0, 8'h00, 8'h1F, 8'h03, 1'b1);
    vs_rise();
    chk("c_simul_fd", fd_count, 4);
    vs_fall();
    line(0, 2, 8'h07, 8'hE0, 8'h1C, 1'b1, 1'b0);
    vs_rise();
    chk("c_writes", wr_count, 536 + 25344 + 8);
    chk("c_fd", fd_count, 5);
    vs_fall();
    for (int l = 0; l < 10; l++) line(l, 60, 8'h00, 8'h1F, 8'h03, 1'b1, 1'b0);
    for (int x = 0; x < 50; x++) pix(x, 10, 8'hF8, 8'h00, 8'hE0, 1'b1);
    @(negedge CLK);
    RESET = 1'b1;
    CAM_DATA = 8'h07;
    @(negedge CLK);
    chk_zero("midreset");
    RESET = 1'b0;
    base_wr = wr_count;
    base_fd = fd_count;
    for (int x = 0; x < 20; x++) pix(x, 10, 8'hF8, 8'h00, 8'hE0, 1'b0);
    repeat (2) drive(8'h00, 1'b0, 1'b0);
    line(11, 20, 8'hF8, 8'h00, 8'hE0, 1'b0, 1'b0);
    vs_rise();
    chk("r_no_writes", wr_count - base_wr, 0);
    chk("r_no_fd", fd_count - base_fd, 0);
    vs_fall();
    line(0, 3, 8'hF8, 8'h00, 8'hE0, 1'b1, 1'b0);
    vs_rise();
    chk("r_resume_writes", wr_count - base_wr, 3);
    chk("r_resume_fd", fd_count - base_fd, 1);
    chk("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cam_downsampler.md
Name: cam_downsampler

Overview:
- Front end of the camera path: the writer that fills the frame buffer read by the colour-detect logic.
- Captures the OV7670 RGB565 byte stream (two bytes per pixel) and packs each pixel to RGB332.
- Writes each packed pixel into the SCREEN_WIDTH x SCREEN_HEIGHT M9K frame buffer with a linear address and a one-cycle write enable.
- Pulses FRAME_DONE at the end of every captured frame.

Parameters:
SCREEN_WIDTH, 176, pixels per line written; pixels beyond this are dropped
SCREEN_HEIGHT, 144, lines per frame written; lines beyond this are dropped
ADDR_W, 15, frame buffer address width (176*144 = 25344 < 2^15)

Ports:
CLK  input  1  camera pixel clock; all inputs sampled on rising edge
RESET  input  1  synchronous, active-high reset
CAM_DATA  input  8  camera data byte
CAM_HREF  input  1  high while line bytes are valid
CAM_VSYNC  input  1  high during vertical blanking (frame boundary)
PIXEL_OUT  output  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}
W_ADDR  output  ADDR_W  frame buffer write address = Y*SCREEN_WIDTH + X
W_EN  output  1  one-cycle write strobe
X_ADDR  output  10  column of current/last write
Y_ADDR  output  10  row of current/last write
FRAME_DONE  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset: PIXEL_OUT=0, W_ADDR=0, W_EN=0, X_ADDR=0, Y_ADDR=0, FRAME_DONE=0, byte phase=0, state=SYNC. Reset mid-frame abandons the frame; no write or FRAME_DONE is issued for it.
- CAM_HREF and CAM_VSYNC are registered once internally (prev copies) for edge detection.
- State SYNC: ignore all data; on CAM_VSYNC falling edge go to IDLE. Partial frames after reset are never written.
- State IDLE: wait for CAM_HREF high, then go to LINE (data sampled the same cycle).
- State LINE, while CAM_HREF=1:
  - Phase 0: latch byte as HI, set phase 1.
  - Phase 1: form pixel {HI[7:5], HI[2:0], CAM_DATA[4:3]}, set phase 0.
  - If X<SCREEN_WIDTH and Y<SCREEN_HEIGHT: next cycle W_EN=1, PIXEL_OUT=pixel, W_ADDR=Y*SCREEN_WIDTH+X, X_ADDR/Y_ADDR=X/Y.
  - X increments after every completed pixel, saturating at 1023.
  - Write latency: 1 cycle after the second byte is sampled.
- CAM_HREF falling: X=0, Y=Y+1 (saturate at 1023), phase forced 0, a dangling odd byte is discarded, return to IDLE.
- CAM_VSYNC rising, any state except SYNC:
  - FRAME_DONE=1 for one cycle if at least one write occurred this frame.
  - X=0, Y=0, phase=0, go to IDLE.
  - VSYNC rising while HREF is high terminates the line; the second byte of an incomplete pixel is not written.
- W_ADDR is computed with a registered multiply-free accumulator: a row base adds SCREEN_WIDTH per line and is added to X. Result width is ADDR_W; overflow cannot occur within bounds.
- W_EN is never high for two writes to the same address within one line. PIXEL_OUT and W_ADDR hold their last value when W_EN=0.
- Simultaneous CAM_HREF falling and CAM_VSYNC rising: the VSYNC handling wins (Y=0, not Y+1).

Optional Feature:
TEST_PATTERN_EN
- Defined: PIXEL_OUT is replaced by colour bars keyed on Y_ADDR, 3 bars of 48 rows:
  - Y<48: 8'hE0 (red)
  - 48<=Y<96: 8'h1C (green)
  - Y>=96: 8'h03 (blue)
- Defined: addressing, timing, W_EN and FRAME_DONE are unchanged, and CAM_DATA is ignored.
- Undefined: camera-derived pixels as above.

Test Plan:
- Reset, then a full frame before any VSYNC falling edge -> zero W_EN pulses, FRAME_DONE stays 0.
- After VSYNC fall, one line of bytes F8,00 repeated 176 times -> 176 writes, PIXEL_OUT=8'hE0, W_ADDR 0..175, Y_ADDR=0.
- Bytes 07,E0 (green) on line 2 -> PIXEL_OUT=8'h1C, W_ADDR=352..527; bytes 00,1F -> PIXEL_OUT=8'h03.
- Line of 200 pixels with 145 lines, then VSYNC rise -> exactly 25344 writes, last W_ADDR=25343, one FRAME_DONE pulse.
- Line ending with an odd byte, then HREF fall -> no write for the dangling byte; next line starts X=0, phase 0.
- RESET asserted at pixel 50 of line 10 -> all outputs 0 next cycle, no FRAME_DONE, writes resume only after the next VSYNC falling edge.
